// File: rtl/screen_tile_writer.sv
// Tile-screen producer: turns write/fill/clear commands into row-major
// screen-memory writes, optionally deferred to the next vsync falling edge.
module screen_tile_writer #(
    parameter int COLS        = 40,
    parameter int ROWS        = 30,
    parameter int WAIT_VBLANK = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_col,
    input  logic [4:0]  cmd_row,
    input  logic [5:0]  cmd_w,
    input  logic [4:0]  cmd_h,
    input  logic [3:0]  cmd_code,
    input  logic        vsync,
    output logic        we,
    output logic [10:0] waddr,
    output logic [3:0]  wdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [5:0]  cur_col_q, cur_col_d;
    logic [5:0]  end_col_q, end_col_d;
    logic [4:0]  cur_row_q, cur_row_d;
    logic [4:0]  end_row_q, end_row_d;
    logic [3:0]  code_q, code_d;
    logic        vs_q;

    logic [6:0]  n_col, n_row, n_w, n_h;
    logic [6:0]  room_c, room_r, ew, eh;
    logic [6:0]  ecol, erow;
    logic        empty;
    logic [10:0] addr;

    // Normalise and clip the incoming command
    always_comb begin
        n_col = {1'b0, cmd_col};
        n_row = {2'b0, cmd_row};
        n_w   = {1'b0, cmd_w};
        n_h   = {2'b0, cmd_h};
        unique case (cmd_op)
            2'd0: begin
                n_w = 7'd1;
                n_h = 7'd1;
            end
            2'd2: begin
                n_col = 7'd0;
                n_row = 7'd0;
                n_w   = 7'(COLS);
                n_h   = 7'(ROWS);
            end
            default: ;
        endcase
        empty = (cmd_op == 2'd3) || (n_col >= 7'(COLS)) ||
                (n_row >= 7'(ROWS)) || (n_w == 7'd0) || (n_h == 7'd0);
        room_c = 7'(COLS) - n_col;
        room_r = 7'(ROWS) - n_row;
        ew     = (n_w < room_c) ? n_w : room_c;
        eh     = (n_h < room_r) ? n_h : room_r;
        ecol   = n_col + ew - 7'd1;
        erow   = n_row + eh - 7'd1;
    end

    // addr = col + 40*row
    assign addr = {5'b0, cur_col_q} + {1'b0, cur_row_q, 5'b0} +
                  {3'b0, cur_row_q, 3'b0};

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign we        = (state_q == S_WRITE);
    assign waddr     = we ? addr : 11'd0;
    assign wdata     = we ? code_q : 4'd0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        end_col_d = end_col_q;
        end_row_d = end_row_q;
        code_d    = code_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    col_d     = n_col[5:0];
                    cur_col_d = n_col[5:0];
                    cur_row_d = n_row[4:0];
                    end_col_d = ecol[5:0];
                    end_row_d = erow[4:0];
                    code_d    = cmd_code;
                    if (empty)
                        state_d = S_DONE;
                    else if (WAIT_VBLANK != 0)
                        state_d = S_WAITV;
                    else
                        state_d = S_WRITE;
                end
            end
            S_WAITV: begin
                if (vs_q && !vsync)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cur_col_q == end_col_q) begin
                    cur_col_d = col_q;
                    if (cur_row_q == end_row_q)
                        state_d = S_DONE;
                    else
                        cur_row_d = cur_row_q + 5'd1;
                end else begin
                    cur_col_d = cur_col_q + 6'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            col_q     <= 6'd0;
            cur_col_q <= 6'd0;
            cur_row_q <= 5'd0;
            end_col_q <= 6'd0;
            end_row_q <= 5'd0;
            code_q    <= 4'd0;
            vs_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            end_col_q <= end_col_d;
            end_row_q <= end_row_d;
            code_q    <= code_d;
            vs_q      <= vsync;
        end
    end

endmodule
